// File: rtl/usb_rx_pkg.sv
// Shared constants, types and helpers for the USB receive phase recovery slice.
package usb_rx_pkg;

  // Phases per window; fixed to match the 5-phase clock generator.
  localparam int NPH = 5;
  // Width of each per-position edge counter.
  localparam int HIST_W = 4;
  // Total edges seen before the histogram is trusted.
  localparam int LOCK_EDGES = 8;

  typedef logic [2:0] phase_t;

  localparam phase_t PHASE_RESET = 3'd2;

  // rx_count encoding.
  localparam logic [1:0] RX_NONE = 2'd0;
  localparam logic [1:0] RX_ONE  = 2'd1;
  localparam logic [1:0] RX_TWO  = 2'd2;

  function automatic phase_t wrap_inc(input phase_t p);
    return (p == phase_t'(NPH - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic phase_t wrap_dec(input phase_t p);
    return (p == 3'd0) ? phase_t'(NPH - 1) : p - 3'd1;
  endfunction

  // A bit equal to the previous line level decodes to 1, a transition to 0.
  function automatic logic nrzi_dec(input logic b, input logic last);
    return ~(b ^ last);
  endfunction

endpackage

// File: rtl/usb_rx_edge_hist.sv
// Edge histogram: per-position edge counters with halving on overflow,
// argmax-based target phase and a saturating total-edge lock counter.
module usb_rx_edge_hist
  import usb_rx_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           samples_valid,
  input  logic [NPH-1:0] samples,
  input  logic [NPH-1:0] prev,
  output phase_t         target,
  output logic           lock_upd
);

  localparam int TOT_W = $clog2(LOCK_EDGES + 1);

  logic [NPH-1:0]    edge_vec;
  logic [HIST_W:0]   sum [NPH];
  logic [HIST_W-1:0] cnt_reg [NPH];
  logic [HIST_W-1:0] cnt_next [NPH];
  logic              overflow;
  phase_t            best_idx;
  logic [HIST_W-1:0] best_cnt;
  logic [TOT_W-1:0]  total_reg;
  logic [TOT_W-1:0]  total_next;
  logic [TOT_W:0]    edge_total;
  logic [TOT_W:0]    total_sum;

  // Edge just before phase 0 compares against the last phase of the previous window.
  assign edge_vec[0] = prev[NPH-1] ^ samples[0];

  genvar gi;
  generate
    for (gi = 1; gi < NPH; gi++) begin : g_edge
      assign edge_vec[gi] = samples[gi-1] ^ samples[gi];
    end
    for (gi = 0; gi < NPH; gi++) begin : g_sum
      assign sum[gi] = {1'b0, cnt_reg[gi]} + {{HIST_W{1'b0}}, edge_vec[gi]};
    end
  endgenerate

  // Updated counts; any overflow halves every counter so their ratios survive.
  always_comb begin
    overflow = 1'b0;
    for (int i = 0; i < NPH; i++) begin
      overflow = overflow | sum[i][HIST_W];
    end
    for (int i = 0; i < NPH; i++) begin
      cnt_next[i] = overflow ? sum[i][HIST_W:1] : sum[i][HIST_W-1:0];
    end
  end

  // Argmax over the updated counts, lowest position wins ties; sample two phases after the edge.
  always_comb begin
    best_idx = 3'd0;
    best_cnt = cnt_next[0];
    for (int i = 1; i < NPH; i++) begin
      if (cnt_next[i] > best_cnt) begin
        best_idx = phase_t'(i);
        best_cnt = cnt_next[i];
      end
    end
    target = wrap_inc(wrap_inc(best_idx));
  end

  // Saturating total-edge count; reaching LOCK_EDGES is permanent until reset.
  always_comb begin
    edge_total = '0;
    for (int i = 0; i < NPH; i++) begin
      edge_total = edge_total + {{TOT_W{1'b0}}, edge_vec[i]};
    end
    total_sum = {1'b0, total_reg} + edge_total;
    if (total_sum >= (TOT_W+1)'(LOCK_EDGES)) begin
      total_next = TOT_W'(LOCK_EDGES);
    end else begin
      total_next = total_sum[TOT_W-1:0];
    end
    lock_upd = (total_next == TOT_W'(LOCK_EDGES));
  end

  // Histogram and edge total advance once per valid window.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NPH; i++) begin
        cnt_reg[i] <= '0;
      end
      total_reg <= '0;
    end else if (samples_valid) begin
      for (int i = 0; i < NPH; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
      total_reg <= total_next;
    end
  end

endmodule

// File: rtl/usb_rx_phase_recover.sv
// USB receive phase recovery: tracks the best of 5 sampling phases, emits
// 0/1/2 NRZI-decoded bits per window.
// Optional feature macro: USB_UNSTUFF_EN (bit unstuffing and stuff_err output).
module usb_rx_phase_recover
  import usb_rx_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           samples_valid,
  input  logic [NPH-1:0] samples,
  output phase_t         phase_sel,
  output logic           locked,
  output logic [1:0]     rx_count,
  output logic [1:0]     rx_data
`ifdef USB_UNSTUFF_EN
  ,
  output logic           stuff_err
`endif
);

  logic [NPH-1:0] prev_reg;
  phase_t         phase_reg;
  phase_t         phase_next;
  phase_t         target;
  logic           lock_upd;
  logic           locked_reg;
  logic           last_reg;
  logic           last_next;
  logic [1:0]     rx_count_reg;
  logic [1:0]     rx_data_reg;
  logic [3:0]     diff;
  logic [1:0]     raw_n;
  logic           raw_b0;
  logic           raw_b1;
  logic [1:0]     dec_bits;
  logic [1:0]     out_cnt;
  logic [1:0]     out_bits;
`ifdef USB_UNSTUFF_EN
  logic [2:0]     ones_reg;
  logic [2:0]     ones_next;
  logic           stuff_err_reg;
  logic           err_next;
`endif

  usb_rx_edge_hist u_hist (
    .clock         (clock),
    .reset         (reset),
    .samples_valid (samples_valid),
    .samples       (samples),
    .prev          (prev_reg),
    .target        (target),
    .lock_upd      (lock_upd)
  );

  // One step per window toward the target along the shorter way round the circle.
  always_comb begin
    diff = {1'b0, target} + 4'd5 - {1'b0, phase_reg};
    if (diff >= 4'd5) begin
      diff = diff - 4'd5;
    end
    phase_next = phase_reg;
    if (diff == 4'd1 || diff == 4'd2) begin
      phase_next = wrap_inc(phase_reg);
    end else if (diff != 4'd0) begin
      phase_next = wrap_dec(phase_reg);
    end
  end

  // Pick raw bits: a forward wrap resamples the same bit, a backward wrap catches an extra one.
  always_comb begin
    raw_n  = RX_ONE;
    raw_b0 = samples[phase_next];
    raw_b1 = 1'b0;
    if (phase_reg == phase_t'(NPH - 1) && phase_next == 3'd0) begin
      raw_n  = RX_NONE;
      raw_b0 = 1'b0;
    end else if (phase_reg == 3'd0 && phase_next == phase_t'(NPH - 1)) begin
      raw_n  = RX_TWO;
      raw_b0 = prev_reg[NPH-1];
      raw_b1 = samples[NPH-1];
    end
  end

  // NRZI decode in emission order; the line level carries across windows.
  always_comb begin
    dec_bits[0] = nrzi_dec(raw_b0, last_reg);
    dec_bits[1] = nrzi_dec(raw_b1, (raw_n == RX_NONE) ? last_reg : raw_b0);
    case (raw_n)
      RX_ONE:  last_next = raw_b0;
      RX_TWO:  last_next = raw_b1;
      default: last_next = last_reg;
    endcase
  end

`ifdef USB_UNSTUFF_EN
  // Drop the bit following six decoded ones; a dropped 1 is a stuffing error.
  always_comb begin
    out_cnt   = RX_NONE;
    out_bits  = 2'b00;
    ones_next = ones_reg;
    err_next  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (2'(k) < raw_n) begin
        if (ones_next == 3'd6) begin
          err_next  = err_next | dec_bits[k];
          ones_next = 3'd0;
        end else begin
          out_bits[out_cnt[0]] = dec_bits[k];
          out_cnt   = out_cnt + 2'd1;
          ones_next = dec_bits[k] ? ones_next + 3'd1 : 3'd0;
        end
      end
    end
  end
`else
  // Without unstuffing every decoded bit goes straight out, packed from [0].
  always_comb begin
    out_cnt  = raw_n;
    out_bits = 2'b00;
    if (raw_n != RX_NONE) begin
      out_bits[0] = dec_bits[0];
    end
    if (raw_n == RX_TWO) begin
      out_bits[1] = dec_bits[1];
    end
  end
`endif

  // Window state and registered outputs; bits only leave once the histogram is trusted.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_reg     <= '1;
      phase_reg    <= PHASE_RESET;
      locked_reg   <= 1'b0;
      last_reg     <= 1'b1;
      rx_count_reg <= RX_NONE;
      rx_data_reg  <= 2'b00;
`ifdef USB_UNSTUFF_EN
      ones_reg      <= 3'd0;
      stuff_err_reg <= 1'b0;
`endif
    end else begin
      rx_count_reg <= RX_NONE;
`ifdef USB_UNSTUFF_EN
      stuff_err_reg <= 1'b0;
`endif
      if (samples_valid) begin
        prev_reg     <= samples;
        phase_reg    <= phase_next;
        locked_reg   <= lock_upd;
        last_reg     <= last_next;
        rx_count_reg <= lock_upd ? out_cnt : RX_NONE;
        rx_data_reg  <= lock_upd ? out_bits : 2'b00;
`ifdef USB_UNSTUFF_EN
        ones_reg      <= ones_next;
        stuff_err_reg <= lock_upd & err_next;
`endif
      end
    end
  end

  assign phase_sel = phase_reg;
  assign locked    = locked_reg;
  assign rx_count  = rx_count_reg;
  assign rx_data   = rx_data_reg;
`ifdef USB_UNSTUFF_EN
  assign stuff_err = stuff_err_reg;
`endif

endmodule
